// File: rtl/isdu_pkg.sv
// isdu_pkg -- shared definitions for the ISDU control unit and its datapath.
//   state_t      : control FSM states (pause states exist only when
//                  ISDU_PAUSE_EN is defined)
//   OP_*         : Opcode field values (IR[15:12])
//   ALUK_*       : ALU function select
//   ADDR2_*      : address-adder second operand select
//   PCMUX_*      : PC source select
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_F1,
    S_F2,
    S_F3,
    S_DECODE,
    S_EX_ADD,
    S_EX_AND,
    S_EX_NOT,
    S_EX_BR,
    S_EX_JMP,
    S_EX_JSR1,
    S_EX_JSR2,
    S_EX_LDR1,
    S_EX_LDR2,
    S_EX_LDR3,
    S_EX_STR1,
    S_EX_STR2,
    S_EX_STR3
`ifdef ISDU_PAUSE_EN
    ,
    S_PAUSE_IR1,
    S_PAUSE_IR2
`endif
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

endpackage

// File: rtl/isdu_ctrl.sv
// isdu_ctrl -- instruction sequencing/decode unit for a small LC-3 style CPU.
//
// Optional feature: define ISDU_PAUSE_EN to make opcode 1101 a PAUSE that
// waits for a full press/release of Continue; otherwise 1101 is a NOP.
//
// Parameter:
//   MEM_WAIT (1..7) : cycles each memory read/write state is held.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   Run, Continue       : start from HALTED, release from PAUSE
//   Opcode, IR_5, IR_11 : instruction fields, BEN : branch enable
//   LD_* / Gate*        : register loads and bus drivers (one gate max)
//   DRMUX..MIO_EN, ALUK, ADDR2MUX, PCMUX : datapath selects
//   Mem_OE, Mem_WE      : active-low memory strobes
//   dbg_state           : current FSM state, for observation only
//
// Outputs are Moore: decoded from the registered state (plus the wait counter
// and the static instruction fields) only. The wait counter runs only inside
// memory states and returns to zero on every state change.
module isdu_ctrl
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_PC,
  output logic       LD_IR,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_CC,
  output logic       LD_BEN,
  output logic       LD_REG,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic [1:0] ALUK,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] PCMUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output state_t     dbg_state
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       mem_last;

  assign mem_last  = (wait_cnt == WAIT_LAST);
  assign dbg_state = state;

`ifndef ISDU_PAUSE_EN
  // Continue only matters when pause support is built in.
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_HALTED;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_HALTED: if (Run) state <= S_F1;
        S_F1:     state <= S_F2;
        S_F2: begin
          if (mem_last) state <= S_F3;
          else          wait_cnt <= wait_cnt + 3'd1;
        end
        S_F3:     state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_ADD: state <= S_EX_ADD;
            OP_AND: state <= S_EX_AND;
            OP_NOT: state <= S_EX_NOT;
            OP_BR:  state <= S_EX_BR;
            OP_JMP: state <= S_EX_JMP;
            OP_JSR: state <= S_EX_JSR1;
            OP_LDR: state <= S_EX_LDR1;
            OP_STR: state <= S_EX_STR1;
`ifdef ISDU_PAUSE_EN
            OP_PAUSE: state <= S_PAUSE_IR1;
`endif
            default: state <= S_F1;
          endcase
        end
        S_EX_JSR1: state <= S_EX_JSR2;
        S_EX_LDR1: state <= S_EX_LDR2;
        S_EX_LDR2: begin
          if (mem_last) state <= S_EX_LDR3;
          else          wait_cnt <= wait_cnt + 3'd1;
        end
        S_EX_STR1: state <= S_EX_STR2;
        S_EX_STR2: state <= S_EX_STR3;
        S_EX_STR3: begin
          if (mem_last) state <= S_F1;
          else          wait_cnt <= wait_cnt + 3'd1;
        end
`ifdef ISDU_PAUSE_EN
        // Two-phase pause: wait for press, then for release, so one press
        // advances exactly one instruction.
        S_PAUSE_IR1: if (Continue)  state <= S_PAUSE_IR2;
        S_PAUSE_IR2: if (!Continue) state <= S_F1;
`endif
        default: state <= S_F1;
      endcase
    end
  end

  always_comb begin
    LD_PC      = 1'b0;
    LD_IR      = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_CC      = 1'b0;
    LD_BEN     = 1'b0;
    LD_REG     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    MIO_EN     = 1'b0;
    ALUK       = ALUK_ADD;
    ADDR2MUX   = ADDR2_ZERO;
    PCMUX      = PCMUX_INC;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (state)
      S_F1: begin
        LD_MAR = 1'b1;
        GatePC = 1'b1;
        LD_PC  = 1'b1;
      end
      S_F2, S_EX_LDR2: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = mem_last;  // capture only once the read data has settled
      end
      S_F3: begin
        LD_IR   = 1'b1;
        GateMDR = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_EX_ADD, S_EX_AND, S_EX_NOT: begin
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        if (state == S_EX_AND)      ALUK = ALUK_AND;
        else if (state == S_EX_NOT) ALUK = ALUK_NOT;
      end
      S_EX_BR: begin
        if (BEN) begin
          LD_PC    = 1'b1;
          PCMUX    = PCMUX_ADDER;
          ADDR1MUX = 1'b1;
          ADDR2MUX = ADDR2_OFF9;
        end
      end
      S_EX_JMP: begin
        LD_PC = 1'b1;
        PCMUX = PCMUX_ADDER;
      end
      S_EX_JSR1: begin
        DRMUX  = 1'b1;
        GatePC = 1'b1;
        LD_REG = 1'b1;
      end
      S_EX_JSR2: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDER;
        ADDR1MUX = IR_11;
        ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
      end
      S_EX_LDR1, S_EX_STR1: begin
        LD_MAR     = 1'b1;
        GateMARMUX = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
      end
      S_EX_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_EX_STR2: begin
        LD_MDR  = 1'b1;
        GateALU = 1'b1;
        ALUK    = ALUK_PASS;
        SR1MUX  = 1'b1;
      end
      S_EX_STR3: Mem_WE = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// tb_isdu_ctrl -- self-checking bench for isdu_ctrl.
// The reference model writes out, per instruction, the cycle-by-cycle
// control word the unit must show, straight from the instruction rules.
// A negedge process compares DUT state + controls against that queue.
module tb_isdu_ctrl;
  import isdu_pkg::*;

  localparam int W = 3;

  logic       Clk, Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_PC, LD_IR, LD_MAR, LD_MDR, LD_CC, LD_BEN, LD_REG;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0] ALUK, ADDR2MUX, PCMUX;
  logic       Mem_OE, Mem_WE;
  state_t     dbg_state;

  isdu_ctrl #(.MEM_WAIT(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_REG(LD_REG),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ALUK(ALUK), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Control word layout (bit 23 down to 0).
  localparam logic [23:0] B_LD_PC  = 24'h800000;
  localparam logic [23:0] B_LD_IR  = 24'h400000;
  localparam logic [23:0] B_LD_MAR = 24'h200000;
  localparam logic [23:0] B_LD_MDR = 24'h100000;
  localparam logic [23:0] B_LD_CC  = 24'h080000;
  localparam logic [23:0] B_LD_BEN = 24'h040000;
  localparam logic [23:0] B_LD_REG = 24'h020000;
  localparam logic [23:0] B_GPC    = 24'h010000;
  localparam logic [23:0] B_GMDR   = 24'h008000;
  localparam logic [23:0] B_GALU   = 24'h004000;
  localparam logic [23:0] B_GMMUX  = 24'h002000;
  localparam logic [23:0] B_DRMUX  = 24'h001000;
  localparam logic [23:0] B_SR1MUX = 24'h000800;
  localparam logic [23:0] B_SR2MUX = 24'h000400;
  localparam logic [23:0] B_A1MUX  = 24'h000200;
  localparam logic [23:0] B_MIO    = 24'h000100;
  localparam logic [23:0] B_OE     = 24'h000002;
  localparam logic [23:0] B_WE     = 24'h000001;
  localparam logic [23:0] IDLE     = 24'h000003;

  function automatic logic [23:0] aluk_f(input logic [1:0] v);
    return {16'b0, v, 6'b0};
  endfunction
  function automatic logic [23:0] addr2_f(input logic [1:0] v);
    return {18'b0, v, 4'b0};
  endfunction
  function automatic logic [23:0] pcmux_f(input logic [1:0] v);
    return {20'b0, v, 2'b0};
  endfunction

  logic [28:0] obs;
  assign obs = {dbg_state, LD_PC, LD_IR, LD_MAR, LD_MDR, LD_CC, LD_BEN, LD_REG,
                GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, MIO_EN, ALUK, ADDR2MUX, PCMUX, Mem_OE, Mem_WE};

  // ---------------- scoreboard ----------------
  logic [28:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s: got state=%0d ctl=%h, required state=%0d ctl=%h",
                 n, obs[28:24], obs[23:0], e[28:24], e[23:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Queue the word the DUT must show during the current cycle, then advance.
  task automatic expect_cycle(input state_t st, input logic [23:0] ctl,
                              input string name);
    exp_q.push_back({st, ctl});
    name_q.push_back(name);
    @(posedge Clk);
    #1;
  endtask

  task automatic mem_read(input state_t st, input string name);
    for (int i = 0; i < W; i++)
      expect_cycle(st, (IDLE & ~B_OE) | B_MIO | ((i == W - 1) ? B_LD_MDR : 24'h0), name);
  endtask

  task automatic start_run();
    Run = 1'b1;
    expect_cycle(S_HALTED, IDLE, "halted_run");
    Run = 1'b0;
  endtask

  // Called at the start of an F1 cycle; models one complete instruction.
  task automatic run_instr(input logic [3:0] op, input logic i5, input logic i11,
                           input logic ben, input int pre, input int hold);
    Opcode = op; IR_5 = i5; IR_11 = i11; BEN = ben; Continue = 1'b0;
    expect_cycle(S_F1, IDLE | B_LD_MAR | B_GPC | B_LD_PC, "F1");
    mem_read(S_F2, "F2");
    expect_cycle(S_F3, IDLE | B_LD_IR | B_GMDR, "F3");
    expect_cycle(S_DECODE, IDLE | B_LD_BEN, "DECODE");
    case (op)
      4'b0001: expect_cycle(S_EX_ADD, IDLE | B_GALU | B_LD_REG | B_LD_CC |
                            (i5 ? B_SR2MUX : 24'h0) | aluk_f(2'b00), "EX_ADD");
      4'b0101: expect_cycle(S_EX_AND, IDLE | B_GALU | B_LD_REG | B_LD_CC |
                            (i5 ? B_SR2MUX : 24'h0) | aluk_f(2'b01), "EX_AND");
      4'b1001: expect_cycle(S_EX_NOT, IDLE | B_GALU | B_LD_REG | B_LD_CC |
                            (i5 ? B_SR2MUX : 24'h0) | aluk_f(2'b10), "EX_NOT");
      4'b0000: expect_cycle(S_EX_BR, ben ? (IDLE | B_LD_PC | pcmux_f(2'b10) |
                            B_A1MUX | addr2_f(2'b10)) : IDLE, "EX_BR");
      4'b1100: expect_cycle(S_EX_JMP, IDLE | B_LD_PC | pcmux_f(2'b10), "EX_JMP");
      4'b0100: begin
        expect_cycle(S_EX_JSR1, IDLE | B_DRMUX | B_GPC | B_LD_REG, "EX_JSR1");
        expect_cycle(S_EX_JSR2, IDLE | B_LD_PC | pcmux_f(2'b10) |
                     (i11 ? (B_A1MUX | addr2_f(2'b11)) : 24'h0), "EX_JSR2");
      end
      4'b0110: begin
        expect_cycle(S_EX_LDR1, IDLE | B_LD_MAR | B_GMMUX | addr2_f(2'b01), "EX_LDR1");
        mem_read(S_EX_LDR2, "EX_LDR2");
        expect_cycle(S_EX_LDR3, IDLE | B_GMDR | B_LD_REG | B_LD_CC, "EX_LDR3");
      end
      4'b0111: begin
        expect_cycle(S_EX_STR1, IDLE | B_LD_MAR | B_GMMUX | addr2_f(2'b01), "EX_STR1");
        expect_cycle(S_EX_STR2, IDLE | B_LD_MDR | B_GALU | aluk_f(2'b11) | B_SR1MUX,
                     "EX_STR2");
        for (int i = 0; i < W; i++) expect_cycle(S_EX_STR3, IDLE & ~B_WE, "EX_STR3");
      end
      4'b1101: begin
`ifdef ISDU_PAUSE_EN
        for (int i = 0; i < pre; i++) expect_cycle(S_PAUSE_IR1, IDLE, "PAUSE_IR1");
        Continue = 1'b1;
        expect_cycle(S_PAUSE_IR1, IDLE, "PAUSE_press");
        for (int i = 1; i < hold; i++) expect_cycle(S_PAUSE_IR2, IDLE, "PAUSE_IR2");
        Continue = 1'b0;
        expect_cycle(S_PAUSE_IR2, IDLE, "PAUSE_release");
`else
        Continue = (pre + hold > 0);  // must be ignored without pause support
`endif
      end
      default: ;  // unlisted opcode: straight back to F1
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'h0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    @(posedge Clk); #1;
    expect_cycle(S_HALTED, 24'h000003, "reset_state");
    Reset = 1'b0;
    expect_cycle(S_HALTED, IDLE, "halted_hold");
    expect_cycle(S_HALTED, IDLE, "halted_hold");
    start_run();

    // Directed instruction list.
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0);  // ADD imm
    run_instr(4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);  // ADD reg
    run_instr(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0);  // AND
    run_instr(4'b1001, 1'b0, 1'b0, 1'b0, 0, 0);  // NOT
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 0, 0);  // BR not taken
    run_instr(4'b0000, 1'b0, 1'b0, 1'b1, 0, 0);  // BR taken
    run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 0, 0);  // JMP
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 0, 0);  // JSRR
    run_instr(4'b0100, 1'b0, 1'b1, 1'b0, 0, 0);  // JSR
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 0, 0);  // LDR
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 0, 0);  // STR
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 2, 5);  // PAUSE, Continue held 5
    run_instr(4'b0010, 1'b0, 1'b0, 1'b0, 0, 0);  // NOP

    // Randomised instruction stream.
    for (int k = 0; k < 250; k++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(1, 4));

    // Reset in the middle of a store write, hand-computed words.
    Opcode = 4'b0111; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Continue = 1'b0;
    expect_cycle(S_F1, 24'hA10003, "lit_F1");
    expect_cycle(S_F2, 24'h000101, "lit_F2");
    expect_cycle(S_F2, 24'h000101, "lit_F2");
    expect_cycle(S_F2, 24'h100101, "lit_F2_last");
    expect_cycle(S_F3, 24'h408003, "lit_F3");
    expect_cycle(S_DECODE, 24'h040003, "lit_DECODE");
    expect_cycle(S_EX_STR1, 24'h202013, "lit_STR1");
    expect_cycle(S_EX_STR2, 24'h1048C3, "lit_STR2");
    expect_cycle(S_EX_STR3, 24'h000002, "lit_STR3");
    Reset = 1'b1;
    expect_cycle(S_EX_STR3, 24'h000002, "lit_STR3_rst");
    Reset = 1'b0;
    expect_cycle(S_HALTED, 24'h000003, "reset_mid_write");
    expect_cycle(S_HALTED, 24'h000003, "halted_after_reset");

    // Restart and run one literal ADD to confirm the restart path.
    start_run();
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0);
    expect_cycle(S_F1, 24'hA10003, "lit_F1_after_add");

    @(posedge Clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/isdu_ctrl.md
ISDU_CTRL -- requirements
Module: isdu_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 3, meaning cycles each memory read/write state is held (range 1..7).
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Run  input  1  start/resume execution from HALTED.
REQ-005 Continue  input  1  release from PAUSE states.
REQ-006 Opcode  input  4  IR[15:12].
REQ-007 IR_5  input  1  immediate select for ADD/AND.
REQ-008 IR_11  input  1  JSR vs JSRR select.
REQ-009 BEN  input  1  branch-enable from datapath.
REQ-010 LD_PC, LD_IR, LD_MAR, LD_MDR, LD_CC, LD_BEN, LD_REG  output  1 each  register loads.
REQ-011 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers, at most one high per cycle.
REQ-012 DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  output  1 each  datapath selects; DRMUX=1 selects R7, SR1MUX=1 selects IR[11:9], SR2MUX=1 selects sext imm5, ADDR1MUX=1 selects PC, MIO_EN=1 loads MDR from memory.
REQ-013 ALUK, ADDR2MUX, PCMUX  output  2 each  ALUK 00 ADD/01 AND/10 NOT/11 PASS A; ADDR2MUX 00 zero/01 off6/10 off9/11 off11; PCMUX 00 PC+1/01 Bus/10 adder.
REQ-014 Mem_OE, Mem_WE  output  1 each  active-low memory strobes.

Function
REQ-015 Outputs SHALL be Moore, decoded combinationally from the registered state only; every unlisted control defaults to 0, Mem_OE/Mem_WE default 1.
REQ-016 States: HALTED, F1 (MAR<-PC, PC<-PC+1), F2 (MDR<-M[MAR]), F3 (IR<-MDR), DECODE (LD_BEN), EX_ADD, EX_AND, EX_NOT, EX_BR, EX_JMP, EX_JSR1 (R7<-PC), EX_JSR2 (PC<-target), EX_LDR1 (MAR<-BaseR+off6), EX_LDR2 (read), EX_LDR3 (DR<-MDR, LD_CC), EX_STR1 (MAR<-BaseR+off6), EX_STR2 (MDR<-SR via ALU PASS, SR1MUX=1), EX_STR3 (write), PAUSE_IR1, PAUSE_IR2.
REQ-017 HALTED->F1 when Run=1; else hold.
REQ-018 F1->F2->F3->DECODE->execute by Opcode: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PAUSE; any other opcode->F1 (NOP).
REQ-019 ADD/AND SHALL assert SR2MUX=IR_5, GateALU, LD_REG, LD_CC; NOT same with ALUK=10.
REQ-020 EX_BR SHALL assert LD_PC, PCMUX=10, ADDR1MUX=1, ADDR2MUX=10 only when BEN=1; always ->F1.
REQ-021 EX_JSR2 SHALL use ADDR2MUX=11, ADDR1MUX=1 when IR_11=1, else ADDR2MUX=00, ADDR1MUX=0; EX_JMP uses ADDR2MUX=00, ADDR1MUX=0, PCMUX=10.
REQ-022 F2 and EX_LDR2 SHALL hold Mem_OE=0, MIO_EN=1 for exactly MEM_WAIT cycles, asserting LD_MDR only on the last.
REQ-023 EX_STR3 SHALL hold Mem_WE=0 for exactly MEM_WAIT cycles; Mem_OE stays 1.
REQ-024 Wait counter SHALL clear on every state change; MEM_WAIT=1 gives single-cycle access.
REQ-025 PAUSE_IR1 holds while Continue=0, ->PAUSE_IR2 on Continue=1; PAUSE_IR2 holds while Continue=1, ->F1 on 0 (one instruction per press).
REQ-026 Instruction latency SHALL be fixed: 3+MEM_WAIT (fetch+decode) plus execute-state count (+MEM_WAIT-1 for LDR/STR).

Reset
REQ-027 Reset=1 SHALL force HALTED and clear the wait counter on the next edge, regardless of state, including mid memory access.
REQ-028 In HALTED all loads/gates SHALL be 0, Mem_OE=Mem_WE=1, selects 0.

Configuration
REQ-029 With ISDU_PAUSE_EN defined, opcode 1101 SHALL enter PAUSE_IR1; without it, 1101 SHALL be a NOP (->F1) and PAUSE states SHALL not exist.

Structure
REQ-030 Package isdu_pkg SHALL hold the state enum, opcode constants, and ALUK/ADDR2MUX/PCMUX encodings; datapath shares them.
REQ-031 No sub-module; wait counter stays inline.

Verification
REQ-032 Reset in EX_STR3 mid-write -> next cycle HALTED, Mem_WE=1.
REQ-033 Run pulse, Opcode=0001, IR_5=1, MEM_WAIT=3 -> F1,F2x3,F3,DECODE,EX_ADD with SR2MUX=1, LD_REG=1, then F1; 7 cycles total.
REQ-034 Opcode=0000 with BEN=0 -> EX_BR, LD_PC=0; with BEN=1 -> LD_PC=1, PCMUX=10.
REQ-035 Opcode=0110 -> Mem_OE low 3 cycles in F2 and in EX_LDR2, LD_MDR high only on third cycle.
REQ-036 ISDU_PAUSE_EN defined, Opcode=1101, Continue held 1 for 5 cycles -> exactly one exit to F1 after Continue falls; undefined -> direct to F1.
REQ-037 Opcode=0100, IR_11=0 -> EX_JSR1 DRMUX=1, GatePC, LD_REG; EX_JSR2 ADDR1MUX=0, ADDR2MUX=00, LD_PC.
